// File: rtl/sensor_error_monitor_if.sv
// Status/handshake bundle between the error detector side and the sensor_error_monitor.
// The master drives the raw error and acknowledge; the monitor (slave) drives the alarm outputs.
interface sensor_error_monitor_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 error_in;
  logic                 ack;
  logic                 alarm;
  logic                 alarm_pulse;
  logic [CNT_WIDTH-1:0] err_count;

  modport master (
    output error_in,
    output ack,
    input  alarm,
    input  alarm_pulse,
    input  err_count
  );

  modport slave (
    input  error_in,
    input  ack,
    output alarm,
    output alarm_pulse,
    output err_count
  );
endinterface

// File: rtl/sensor_error_monitor.sv
// Debounces the sensor error flag, latches an alarm until it is acknowledged and counts confirmed events.
// Optional macro SENSOR_MON_SAT_EN: err_count saturates instead of wrapping.
module sensor_error_monitor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sensor_error_monitor_if.slave mon
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PENDING  = 2'd1;
  localparam logic [1:0] ALARM    = 2'd2;
  localparam logic [1:0] WAIT_CLR = 2'd3;

  logic [1:0]           state_q;
  logic [DW-1:0]        dcnt_q;
  logic                 pulse_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Every output comes straight from a register so no input can ripple through.
  assign mon.alarm       = (state_q == ALARM);
  assign mon.alarm_pulse = pulse_q;
  assign mon.err_count   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mon.error_in) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= ALARM;
              dcnt_q  <= '0;
              pulse_q <= 1'b1;
`ifdef SENSOR_MON_SAT_EN
              if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + CNT_WIDTH'(1);
`else
              cnt_q <= cnt_q + CNT_WIDTH'(1);
`endif
            end else begin
              state_q <= PENDING;
              dcnt_q  <= DW'(1);
            end
          end
        end
        PENDING: begin
          if (!mon.error_in) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
          end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            state_q <= ALARM;
            dcnt_q  <= '0;
            pulse_q <= 1'b1;
`ifdef SENSOR_MON_SAT_EN
            if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + CNT_WIDTH'(1);
`else
            cnt_q <= cnt_q + CNT_WIDTH'(1);
`endif
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        ALARM: begin
          // An ack while the error persists parks in WAIT_CLR so it cannot re-confirm.
          if (mon.ack) state_q <= mon.error_in ? WAIT_CLR : IDLE;
        end
        WAIT_CLR: begin
          if (!mon.error_in) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          dcnt_q  <= '0;
        end
      endcase
    end
  end

endmodule
